mem_port_ctrl: RTL and testbench

Cache-side initiator for the banked main-memory port. Accepts 128-bit block refill requests and 32-bit write-through stores from the data cache controller, buffers stores in a small FIFO, and sequences them onto the memory's single-outstanding `mem_read`/`mem_write`/`ready` handshake. Sits between the cache controller FSM and the 128-bit-block main memory.

---
 rtl/mem_port_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_mem_port_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_ctrl.sv
// rtl/mem_port_ctrl.sv - cache-side initiator for the banked 128-bit main-memory port
//
// Purpose: latches block refill requests, buffers write-through stores in a
// WB_DEPTH-entry FIFO and sequences both onto the single-outstanding
// mem_read/mem_write/mem_ready handshake.
//
// Optional feature macro: MEMPORT_RAW_BYPASS_EN
//   defined   - a pending refill overtakes buffered stores unless a buffered
//               (or same-cycle) store hits the refill block, in which case the
//               FIFO is drained completely before the read.
//   undefined - the FIFO is always drained before a pending refill issues.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   refill_req/refill_addr        refill request pulse and byte address
//   refill_busy/done/data         refill pending, completion pulse, 128-bit block
//   wr_req/wr_addr/wr_data        store enqueue
//   wr_full, busy                 buffer full, controller activity
//   mem_read/mem_write/mem_addr/mem_wdata   memory request outputs
//   mem_block_rdata, mem_ready    memory return block and ready
module mem_port_ctrl #(
  parameter int WB_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         refill_req,
  input  logic [31:0]  refill_addr,
  output logic         refill_busy,
  output logic         refill_done,
  output logic [127:0] refill_data,
  input  logic         wr_req,
  input  logic [31:0]  wr_addr,
  input  logic [31:0]  wr_data,
  output logic         wr_full,
  output logic         busy,
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  input  logic [127:0] mem_block_rdata,
  input  logic         mem_ready
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(WB_DEPTH);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_ISSUE = 3'd1;
  localparam logic [2:0] S_WR_WAIT  = 3'd2;
  localparam logic [2:0] S_RD_ISSUE = 3'd3;
  localparam logic [2:0] S_RD_WAIT  = 3'd4;

  logic [2:0]    r_state;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic [31:0]   r_fifo_addr [WB_DEPTH];
  logic [31:0]   r_fifo_data [WB_DEPTH];
  logic          r_pend;
  logic [31:0]   r_pend_addr;
  logic          r_mem_read;
  logic          r_mem_write;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic          r_refill_done;
  logic [127:0]  r_refill_data;

  logic w_push;
  logic w_pop;
  logic w_match_fifo;
  logic w_match_push;
  logic w_read_ok;

  // Full is taken from the registered count, so a same-cycle pop never
  // makes room for a push.
  assign w_push = wr_req && (r_count != FULL_CNT);
  assign w_pop  = (r_state == S_WR_WAIT) && mem_ready;

  // Does any valid buffered store fall in the pending refill block?
  always_comb begin : match_scan
    logic [PW-1:0] idx;
    w_match_fifo = 1'b0;
    idx          = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      idx = r_rd_ptr + PW'(i);
      if (((PW+1)'(i) < r_count) && (r_fifo_addr[idx][31:4] == r_pend_addr[31:4]))
        w_match_fifo = 1'b1;
    end
  end

  // A store entering the FIFO this cycle is not visible in the scan above
  // but must still hold the read back.
  assign w_match_push = w_push && (wr_addr[31:4] == r_pend_addr[31:4]);

`ifdef MEMPORT_RAW_BYPASS_EN
  // Once a hit is seen the whole FIFO drains, not just up to the hit entry.
  logic r_drain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_drain <= 1'b0;
    else if (r_count == '0)
      r_drain <= 1'b0;
    else if (r_pend && w_match_fifo)
      r_drain <= 1'b1;
  end

  assign w_read_ok = r_pend && !w_match_push &&
                     ((r_count == '0) || (!r_drain && !w_match_fifo));
`else
  assign w_read_ok = r_pend && !w_match_push && (r_count == '0);
`endif

  // Write buffer pointers and count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (w_pop && !w_push)
        r_count <= r_count - 1'b1;
    end
  end

  // Entry storage needs no reset: validity comes from the pointers/count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= wr_addr;
      r_fifo_data[r_wr_ptr] <= wr_data;
    end
  end

  // Refill latch; the flag stays set until the read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
    end else if ((r_state == S_RD_WAIT) && mem_ready) begin
      r_pend <= 1'b0;
    end else if (refill_req && !r_pend) begin
      r_pend      <= 1'b1;
      r_pend_addr <= refill_addr & 32'hFFFF_FFF0;
    end
  end

  // Memory sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_refill_done <= 1'b0;
      r_refill_data <= '0;
    end else begin
      r_refill_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mem_ready) begin
            if (w_read_ok) begin
              r_mem_read <= 1'b1;
              r_mem_addr <= r_pend_addr;
              r_state    <= S_RD_ISSUE;
            end else if (r_count != '0) begin
              r_mem_write <= 1'b1;
              r_mem_addr  <= r_fifo_addr[r_rd_ptr];
              r_mem_wdata <= r_fifo_data[r_rd_ptr];
              r_state     <= S_WR_ISSUE;
            end
          end
        end
        // mem_ready seen during the issue cycle predates the request.
        S_WR_ISSUE: r_state <= S_WR_WAIT;
        S_RD_ISSUE: r_state <= S_RD_WAIT;
        S_WR_WAIT: begin
          if (mem_ready) begin
            r_mem_write <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        S_RD_WAIT: begin
          if (mem_ready) begin
            r_refill_data <= mem_block_rdata;
            r_refill_done <= 1'b1;
            r_mem_read    <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        default: begin
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign refill_done = r_refill_done;
  assign refill_data = r_refill_data;
  assign refill_busy = r_pend;
  assign wr_full     = (r_count == FULL_CNT);
  assign busy        = (r_state != S_IDLE) || r_pend || (r_count != '0);

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb/tb_mem_port_ctrl.sv - self-checking bench for mem_port_ctrl
module tb_mem_port_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         refill_req = 1'b0;
  logic [31:0]  refill_addr = '0;
  logic         refill_busy;
  logic         refill_done;
  logic [127:0] refill_data;
  logic         wr_req = 1'b0;
  logic [31:0]  wr_addr = '0;
  logic [31:0]  wr_data = '0;
  logic         wr_full;
  logic         busy;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [127:0] mem_block_rdata = '0;
  logic         mem_ready = 1'b1;

  mem_port_ctrl #(.WB_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .refill_req(refill_req), .refill_addr(refill_addr),
    .refill_busy(refill_busy), .refill_done(refill_done), .refill_data(refill_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_full(wr_full), .busy(busy),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_block_rdata(mem_block_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int mutex_bad = 0;

  // Reference memory: ready low for 2 cycles after the first request cycle,
  // high on the 3rd, then low for one cycle after completion.
  typedef struct packed {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        mlog[$];
  logic [31:0] mem_words [int unsigned];
  int          m_phase = 0;
  logic        m_hold  = 1'b0;

  function automatic logic [127:0] read_block(input logic [31:0] a);
    logic [127:0] b;
    int unsigned  k;
    b = '0;
    for (int n = 0; n < 4; n++) begin
      k = int'({a[31:4], 2'(n)});
      if (mem_words.exists(k))
        b[32*n +: 32] = mem_words[k];
    end
    return b;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase   <= 0;
      mem_ready <= 1'b1;
    end else if (m_hold && m_phase == 0) begin
      mem_ready <= 1'b0;
    end else begin
      case (m_phase)
        0: begin
          mem_ready <= 1'b1;
          if (mem_read || mem_write) begin
            mlog.push_back('{rd: mem_read, addr: mem_addr, data: mem_wdata});
            mem_ready <= 1'b0;
            m_phase   <= 1;
          end
        end
        1: begin
          mem_block_rdata <= read_block(mem_addr);
          m_phase <= 2;
        end
        2: begin
          mem_ready <= 1'b1;
          m_phase   <= 3;
        end
        3: begin
          if (mem_write)
            mem_words[int'(mem_addr[31:2])] = mem_wdata;
          mem_ready <= 1'b0;
          m_phase   <= 4;
        end
        default: begin
          mem_ready <= 1'b1;
          m_phase   <= 0;
        end
      endcase
    end
  end

  always @(negedge clk)
    if (mem_read && mem_write)
      mutex_bad++;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_quiet(input string nm);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    chk({nm, "_quiet_timeout"}, 128'(n < 200), 128'd1);
    repeat (3) tick();
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (refill_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk({nm, "_done_timeout"}, 128'(n < 200), 128'd1);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_req = 1'b0;
  endtask

  typedef struct {
    logic [31:0]  wa;
    logic [31:0]  wd;
    logic [31:0]  ra;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[4];

  initial begin : main
    logic [5:0]  w_hist, r_hist, d_hist, b_hist;
    logic [31:0] cap_addr, cap_data;
    int          rd_idx, exp_idx, nrd, nwr, dones;
    logic        seen_rd, seen_wr;

    vecs[0] = '{32'h0000_0100, 32'h1111_0000, 32'h0000_0104,
                128'h00000000_00000000_DEADBEEF_11110000};
    vecs[1] = '{32'h0000_010C, 32'h1234_5678, 32'h0000_0100,
                128'h12345678_00000000_DEADBEEF_11110000};
    vecs[2] = '{32'h0000_0500, 32'hCAFE_F00D, 32'h0000_010F,
                128'h12345678_00000000_DEADBEEF_11110000};
    vecs[3] = '{32'h0000_0108, 32'hA5A5_A5A5, 32'h0000_0500,
                128'h00000000_00000000_00000000_CAFEF00D};

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_mem_rw", {mem_read, mem_write}, 2'b00);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_refill", {refill_done, refill_busy}, 2'b00);
    chk("rst_refill_data", refill_data, 128'h0);
    chk("rst_status", {wr_full, busy}, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) tick();

    // Single store: mem_write in cycles 2..5
    wr_req = 1'b1; wr_addr = 32'h0000_0104; wr_data = 32'hDEAD_BEEF;
    w_hist = '0; b_hist = '0; cap_addr = '0; cap_data = '0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      wr_req = 1'b0;
      w_hist[c-1] = mem_write;
      b_hist[c-1] = busy;
      if (c == 2) begin
        cap_addr = mem_addr;
        cap_data = mem_wdata;
      end
    end
    chk("store_write_cycles", w_hist, 6'b011110);
    chk("store_addr", cap_addr, 32'h0000_0104);
    chk("store_data", cap_data, 32'hDEAD_BEEF);
    chk("store_busy", b_hist, 6'b011111);
    repeat (2) tick();

    // Refill with memory idle: mem_read cycles 2..5, done in cycle 6
    refill_req = 1'b1; refill_addr = 32'h0000_0100;
    r_hist = '0; d_hist = '0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      refill_req = 1'b0;
      r_hist[c-1] = mem_read;
      d_hist[c-1] = refill_done;
      if (c == 1) chk("refill_busy_set", refill_busy, 1'b1);
      if (c == 2) chk("refill_addr_out", mem_addr, 32'h0000_0100);
    end
    chk("refill_read_cycles", r_hist, 6'b011110);
    chk("refill_done_cycle", d_hist, 6'b100000);
    chk("refill_word1", refill_data[63:32], 32'hDEAD_BEEF);
    tick();
    chk("refill_busy_clr", {refill_busy, refill_done}, 2'b00);

    // Table: store then refill, check returned block
    for (int i = 0; i < 4; i++) begin
      wait_quiet($sformatf("vec%0d", i));
      push(vecs[i].wa, vecs[i].wd);
      refill_req = 1'b1; refill_addr = vecs[i].ra;
      tick();
      refill_req = 1'b0;
      wait_done($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_data", i), refill_data, vecs[i].exp);
    end

    // Full buffer with memory held busy
    wait_quiet("full");
    m_hold = 1'b1;
    tick();
    mlog.delete();
    for (int k = 0; k < 5; k++) begin
      wr_req = 1'b1; wr_addr = 32'h10 + 32'(4*k); wr_data = 32'h1000 + 32'(k);
      if (k == 3) chk("full_before_4th", wr_full, 1'b0);
      if (k == 4) chk("full_after_4th", wr_full, 1'b1);
      tick();
    end
    wr_req = 1'b0;
    chk("full_after_5th", wr_full, 1'b1);
    m_hold = 1'b0;
    wait_quiet("full_drain");
    chk("full_count", mlog.size(), 4);
    for (int k = 0; k < 4 && k < mlog.size(); k++)
      chk($sformatf("full_txn%0d", k), {mlog[k].rd, mlog[k].addr, mlog[k].data},
          {1'b0, 32'h10 + 32'(4*k), 32'h1000 + 32'(k)});

    // Arbitration: non-matching refill
    for (int t = 0; t < 2; t++) begin
      wait_quiet("arb");
      m_hold = 1'b1;
      tick();
      mlog.delete();
      push(32'h0000_0200, 32'h5A5A_0001 + 32'(t));
      push(32'h0000_0300, 32'h3333_3333);
      refill_req = 1'b1; refill_addr = (t == 0) ? 32'h0000_0400 : 32'h0000_0204;
      tick();
      refill_req = 1'b0;
      m_hold = 1'b0;
      wait_done($sformatf("arb%0d", t));
      wait_quiet("arb_end");
      rd_idx = -1;
      foreach (mlog[j]) if (mlog[j].rd) rd_idx = j;
`ifdef MEMPORT_RAW_BYPASS_EN
      exp_idx = (t == 0) ? 0 : 2;
`else
      exp_idx = 2;
`endif
      chk($sformatf("arb%0d_count", t), mlog.size(), 3);
      chk($sformatf("arb%0d_read_pos", t), rd_idx, exp_idx);
      if (rd_idx >= 0)
        chk($sformatf("arb%0d_read_addr", t), mlog[rd_idx].addr,
            (t == 0) ? 32'h0000_0400 : 32'h0000_0200);
      if (t == 1)
        chk("arb1_raw_data", refill_data[31:0], 32'h5A5A_0002);
    end

    // Simultaneous store and refill while idle
    wait_quiet("simul");
    mlog.delete();
    wr_req = 1'b1; wr_addr = 32'h0000_0600; wr_data = 32'h6666_6666;
    refill_req = 1'b1; refill_addr = 32'h0000_0700;
    tick();
    wr_req = 1'b0; refill_req = 1'b0;
    wait_done("simul");
    wait_quiet("simul_end");
    nrd = 0; nwr = 0; seen_rd = 1'b0; seen_wr = 1'b0;
    foreach (mlog[j]) begin
      if (mlog[j].rd) begin
        nrd++;
        if (mlog[j].addr == 32'h0000_0700) seen_rd = 1'b1;
      end else begin
        nwr++;
        if (mlog[j].addr == 32'h0000_0600 && mlog[j].data == 32'h6666_6666) seen_wr = 1'b1;
      end
    end
    chk("simul_counts", {nrd[7:0], nwr[7:0]}, {8'd1, 8'd1});
    chk("simul_both", {seen_rd, seen_wr}, 2'b11);

    // Reset during RD_WAIT of a refill of 0x100
    refill_req = 1'b1; refill_addr = 32'h0000_0100;
    tick();
    refill_req = 1'b0;
    repeat (2) tick();
    chk("rdwait_read_active", mem_read, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_mem", {mem_read, mem_write, mem_addr, mem_wdata}, 66'h0);
    chk("midrst_refill", {refill_done, refill_busy, refill_data}, 130'h0);
    chk("midrst_status", {wr_full, busy}, 2'b00);
    tick();
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (refill_done) dones++;
    end
    chk("postrst_no_done", dones, 0);
    chk("postrst_busy", busy, 1'b0);

    chk("mutex_rw", mutex_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
